// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared state encoding and widths for the instruction loader (INSTR_LOADER_CHECKSUM_EN adds CHK)
package instr_loader_pkg;

    localparam int INSTR_W           = 32;
    localparam int DEFAULT_MAX_WORDS = 64;

    typedef enum logic [2:0] {
        ST_HDR     = 3'd0,
        ST_PAYLOAD = 3'd1,
        ST_WRITE   = 3'd2,
`ifdef INSTR_LOADER_CHECKSUM_EN
        ST_CHK     = 3'd3,
`endif
        ST_DONE    = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

endpackage

// File: rtl/instr_word_packer.sv
// rtl/instr_word_packer.sv - big-endian byte-to-word shift register with byte index
module instr_word_packer
    import instr_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               shift_en,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] word,
    output logic               last_byte
);

    logic [1:0] byte_idx;

    // Index wraps naturally after the fourth byte, so no clear is needed between words.
    assign last_byte = (byte_idx == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            word     <= '0;
            byte_idx <= 2'd0;
        end else if (shift_en) begin
            word     <= {word[INSTR_W-9:0], byte_in};
            byte_idx <= byte_idx + 2'd1;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - serial program image loader; INSTR_LOADER_CHECKSUM_EN enables trailing XOR checksum
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int          MAX_WORDS = DEFAULT_MAX_WORDS,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         byte_in,
    input  logic               byte_valid,
    output logic               byte_ready,
    input  logic               restart,
    output logic [INSTR_W-1:0] ext_instr,
    output logic [31:0]        ext_instr_addr,
    output logic               ext_instr_en,
    output logic               start,
    output logic               error
);

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

    state_t     state;
    logic [7:0] n_words;
    logic [7:0] wcnt;
    logic       accept;
    logic       shift_en;
    logic       last_byte;

`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    assign byte_ready = rst_n && (state == ST_HDR || state == ST_PAYLOAD || state == ST_CHK);
`else
    assign byte_ready = rst_n && (state == ST_HDR || state == ST_PAYLOAD);
`endif

    assign accept   = byte_valid && byte_ready;
    assign shift_en = accept && !restart && (state == ST_PAYLOAD);

    // The packer output is the store data; it cannot move during WRITE since no byte is accepted there.
    instr_word_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (restart || state == ST_HDR),
        .shift_en  (shift_en),
        .byte_in   (byte_in),
        .word      (ext_instr),
        .last_byte (last_byte)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_HDR;
            n_words        <= 8'd0;
            wcnt           <= 8'd0;
            ext_instr_addr <= BASE_ADDR;
            ext_instr_en   <= 1'b0;
            start          <= 1'b0;
            error          <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum           <= 8'd0;
`endif
        end else if (restart) begin
            state        <= ST_HDR;
            ext_instr_en <= 1'b0;
            start        <= 1'b0;
            error        <= 1'b0;
        end else begin
            ext_instr_en <= 1'b0;
            case (state)
                ST_HDR: if (accept) begin
                    if (byte_in == 8'd0 || {24'd0, byte_in} > MAX_W) begin
                        state <= ST_ERR;
                        error <= 1'b1;
                    end else begin
                        n_words        <= byte_in;
                        wcnt           <= 8'd0;
                        ext_instr_addr <= BASE_ADDR;
                        state          <= ST_PAYLOAD;
`ifdef INSTR_LOADER_CHECKSUM_EN
                        csum           <= 8'd0;
`endif
                    end
                end
                ST_PAYLOAD: if (accept) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum <= csum ^ byte_in;
`endif
                    if (last_byte) begin
                        ext_instr_en <= 1'b1;
                        state        <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    ext_instr_addr <= ext_instr_addr + 32'd4;
                    wcnt           <= wcnt + 8'd1;
                    if (wcnt + 8'd1 == n_words) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        state <= ST_CHK;
`else
                        state <= ST_DONE;
                        start <= 1'b1;
`endif
                    end else begin
                        state <= ST_PAYLOAD;
                    end
                end
`ifdef INSTR_LOADER_CHECKSUM_EN
                ST_CHK: if (accept) begin
                    if (byte_in == csum) begin
                        state <= ST_DONE;
                        start <= 1'b1;
                    end else begin
                        state <= ST_ERR;
                        error <= 1'b1;
                    end
                end
`endif
                ST_DONE, ST_ERR: ;
                default: state <= ST_HDR;
            endcase
        end
    end

endmodule
